// File: rtl/mem_access_unit.sv
// Data-memory access controller: maps MEM-stage loads/stores onto a word-wide synchronous RAM,
// handling lane selection, sign/zero extension and read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_fault,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StLoadRd,
        StLoadCap,
        StStoreWr,
        StRmwRd,
        StRmwWr,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            lane_q, lane_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  fault_q, fault_d;

    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_fault_q, rsp_fault_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;

    function automatic logic access_fault(input logic we, input logic [31:0] addr,
                                          input logic [2:0] f3);
        logic bad_f3;
        logic bad_store;
        logic misaligned;
        logic out_of_range;
        bad_f3       = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        bad_store    = we && (f3 == F3_BU || f3 == F3_HU);
        misaligned   = ((f3 == F3_H || f3 == F3_HU) && addr[0]) ||
                       ((f3 == F3_W) && (addr[1:0] != 2'b00));
        out_of_range = (addr >> (ADDR_WIDTH + 2)) != 32'd0;
        return bad_f3 || bad_store || misaligned || out_of_range;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_BU:   res = {24'd0, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_HU:   res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed byte or halfword of the word just read back.
    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] data,
                                               input logic half, input logic [1:0] lane);
        logic [31:0] res;
        res = word;
        if (half) begin
            if (lane[1]) begin
                res[31:16] = data;
            end else begin
                res[15:0] = data;
            end
        end else begin
            unique case (lane)
                2'd0: res[7:0]   = data[7:0];
                2'd1: res[15:8]  = data[7:0];
                2'd2: res[23:16] = data[7:0];
                2'd3: res[31:24] = data[7:0];
            endcase
        end
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        fault_d     = fault_q;
        rsp_rdata_d = rsp_rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    funct3_d   = req_funct3;
                    lane_d     = req_addr[1:0];
                    wdata_d    = req_wdata[15:0];
                    fault_d    = access_fault(req_we, req_addr, req_funct3);
                    ram_addr_d = req_addr[ADDR_WIDTH+1:2];
                    if (fault_d) begin
                        rsp_rdata_d = '0;
                        state_d     = StResp;
                    end else if (!req_we) begin
                        state_d = StLoadRd;
                    end else if (req_funct3 == F3_W) begin
                        ram_wdata_d = req_wdata;
                        state_d     = StStoreWr;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoadRd:  state_d = StLoadCap;
            StLoadCap: begin
                rsp_rdata_d = load_extend(ram_rdata, funct3_q, lane_q);
                state_d     = StResp;
            end
            StStoreWr: begin
                rsp_rdata_d = '0;
                state_d     = StResp;
            end
            StRmwRd:   state_d = StRmwWr;
            StRmwWr: begin
                rsp_rdata_d = '0;
                state_d     = StResp;
            end
            StResp:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        // Outputs are registered: decode them from the state being entered.
        req_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_d == StResp);
        rsp_fault_d = (state_d == StResp) && fault_d;
        ram_en_d    = state_d inside {StLoadRd, StStoreWr, StRmwRd, StRmwWr};
        ram_we_d    = state_d inside {StStoreWr, StRmwWr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            funct3_q    <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            fault_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            fault_q     <= fault_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;
    assign ram_addr  = ram_addr_q;
    // Gated by rst so a reset cycle can never commit a write.
    assign ram_en    = ram_en_q & ~rst;
    assign ram_we    = ram_we_q & ~rst;
    // The RMW merge needs the read data that only arrives during the write cycle itself.
    assign ram_wdata = (state_q == StRmwWr) ?
                       merge_lane(ram_rdata, wdata_q, funct3_q[0], lane_q) : ram_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-level reference model predicts each response,
// a negedge monitor checks responses, latencies and RAM activity, and RAM contents are compared.
module tb_mem_access_unit;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [2:0]    req_funct3;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_fault;
    logic [AW-1:0] ram_addr;
    logic          ram_en;
    logic          ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .ram_addr   (ram_addr),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // ---------------- RAM behaviour and reference state ----------------
    logic [31:0]   mem [DEPTH];
    logic [31:0]   ref_mem [DEPTH];
    logic          init_mem;
    logic          poke_en;
    logic [AW-1:0] poke_addr;
    logic [31:0]   poke_data;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else ram_rdata <= mem[ram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        int          en;
        int          we;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   en_cnt = 0;
    int   we_cnt = 0;
    exp_t mon_e;
    int   mon_a;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: byte-addressed little-endian memory, access size from funct3.
    function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                   input logic [31:0] wd);
        exp_t        e;
        int          size;
        int          sh;
        int          idx;
        bit          legal;
        bit          sgn;
        logic [31:0] mask;
        logic [31:0] word;
        logic [31:0] val;
        legal = 1'b1;
        sgn   = 1'b0;
        size  = 4;
        case (f3)
            3'b000:  begin size = 1; sgn = 1'b1; end
            3'b001:  begin size = 2; sgn = 1'b1; end
            3'b010:  size = 4;
            3'b100:  size = 1;
            3'b101:  size = 2;
            default: legal = 1'b0;
        endcase
        e.rdata = '0;
        e.fault = 1'b0;
        if (!legal || (we && !sgn && size != 4) || (addr % 32'(size)) != 0 ||
            addr >= (32'd1 << (AW + 2))) begin
            e.fault = 1'b1;
            e.lat   = 1;
            e.en    = 0;
            e.we    = 0;
            return e;
        end
        idx  = int'(addr / 4);
        sh   = int'(addr % 4) * 8;
        mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
        word = ref_mem[idx];
        if (!we) begin
            val = (word >> sh) & mask;
            if (sgn && size < 4 && val[8*size-1]) val = val | ~mask;
            e.rdata = val;
            e.lat   = 3;
            e.en    = 1;
            e.we    = 0;
        end else begin
            ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
            e.lat = (size == 4) ? 2 : 3;
            e.en  = (size == 4) ? 1 : 2;
            e.we  = 1;
        end
        return e;
    endfunction

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            en_cnt = 0;
            we_cnt = 0;
        end else begin
            if (ram_en) en_cnt++;
            if (ram_en && ram_we) we_cnt++;
            if (rsp_valid) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_a = acc_q.pop_front();
                    check("rsp_fault", 32'(rsp_fault), 32'(mon_e.fault));
                    check("rsp_rdata", rsp_rdata, mon_e.rdata);
                    check("latency", 32'(cyc - mon_a), 32'(mon_e.lat));
                    check("ram_en_cycles", 32'(en_cnt), 32'(mon_e.en));
                    check("ram_we_cycles", 32'(we_cnt), 32'(mon_e.we));
                end
            end
            if (req_valid && req_ready) begin
                acc_q.push_back(cyc);
                en_cnt = 0;
                we_cnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers (drive at posedge + 1) ----------------
    task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, input bit hold, output int waits);
        exp_q.push_back(model(we, addr, f3, wd));
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        req_valid  = 1'b1;
        waits      = 0;
        while (!req_ready && waits < 50) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd);
        int w;
        issue(we, addr, f3, wd, 1'b0, w);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 100) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] d);
        poke_addr = idx[AW-1:0];
        poke_data = d;
        poke_en   = 1'b1;
        @(posedge clk);
        #1;
        poke_en      = 1'b0;
        ref_mem[idx] = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        int          r;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        rst        = 1'b1;
        init_mem   = 1'b1;
        poke_en    = 1'b0;
        poke_addr  = '0;
        poke_data  = '0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        init_mem = 1'b0;

        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        check("reset_ram_en", 32'(ram_en), 32'd0);
        check("reset_ram_we", 32'(ram_we), 32'd0);
        check("reset_ram_addr", 32'(ram_addr), 32'd0);
        check("reset_ram_wdata", ram_wdata, 32'd0);

        // Word store
        req(1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
        wait_idle();
        check("sw_word4", mem[4], 32'hDEADBEEF);

        // Sub-word loads with sign/zero extension
        poke(4, 32'h8081F2F3);
        req(1'b0, 32'h13, 3'b000, 32'h0);
        req(1'b0, 32'h13, 3'b100, 32'h0);
        req(1'b0, 32'h10, 3'b001, 32'h0);
        req(1'b0, 32'h12, 3'b101, 32'h0);
        wait_idle();

        // Read-modify-write stores
        poke(4, 32'h11223344);
        req(1'b1, 32'h11, 3'b000, 32'h000000AA);
        wait_idle();
        check("sb_word4", mem[4], 32'h1122AA44);
        req(1'b1, 32'h12, 3'b001, 32'h1234BEEF);
        wait_idle();
        check("sh_word4", mem[4], 32'hBEEFAA44);
        check("sh_word3_untouched", mem[3], ref_mem[3]);
        check("sh_word5_untouched", mem[5], ref_mem[5]);

        // Faults: misaligned, store with unsigned funct3, out of range, illegal funct3
        req(1'b0, 32'h12, 3'b010, 32'h0);
        req(1'b0, 32'h11, 3'b001, 32'h0);
        req(1'b1, 32'h10, 3'b100, 32'h0);
        req(1'b0, 32'h00001000, 3'b010, 32'h0);
        req(1'b0, 32'h0, 3'b011, 32'h0);
        req(1'b1, 32'h4, 3'b101, 32'h0);
        req(1'b0, 32'h8, 3'b110, 32'h0);
        req(1'b1, 32'h8, 3'b111, 32'h0);
        wait_idle();

        // Reset during the word-store write cycle
        req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_storewr_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_storewr_ready", 32'(req_ready), 32'd1);
        check("rst_storewr_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("rst_storewr_no_rsp", 32'(rsp_valid), 32'd0);
        check("rst_storewr_word8", mem[8], ref_mem[8]);

        // Reset during the read-modify-write write cycle
        req_we = 1'b1; req_addr = 32'h25; req_funct3 = 3'b000; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_rmwwr_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_rmwwr_ready", 32'(req_ready), 32'd1);
        check("rst_rmwwr_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("rst_rmwwr_no_rsp", 32'(rsp_valid), 32'd0);
        check("rst_rmwwr_word9", mem[9], ref_mem[9]);

        // Back-to-back with req_valid held: SW then LW of the same word
        issue(1'b1, 32'h30, 3'b010, 32'h0BADC0DE, 1'b1, w);
        issue(1'b0, 32'h30, 3'b010, 32'h0, 1'b0, w);
        check("b2b_accept_wait", 32'(w), 32'd2);
        wait_idle();

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) addr = $urandom;
            else if (r < 8) addr = $urandom_range(0, 255);
            else addr = $urandom_range(0, 4095);
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
                // Keep most accesses aligned so real traffic dominates.
                if (f3[1:0] == 2'b01 && $urandom_range(0, 7) != 0) addr[0] = 1'b0;
                if (f3 == 3'b010 && $urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            we = 1'($urandom_range(0, 1));
            req(we, addr, f3, $urandom);
        end
        wait_idle();

        for (int i = 0; i < DEPTH; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
